// File: rtl/zed_mem_arbiter.sv
// zed_mem_arbiter: shares the single-port chip RAM between video fetch, the 6502 CPU
// and the host loader.
//
// Video has strict priority, except that a CPU request left waiting MAX_WAIT cycles
// takes the next slot (vid_miss pulses if video was asking). CPU and loader
// share the remaining slots round-robin. The RAM command is registered one cycle
// after the grant. Read data arrives one cycle after that and is routed back by a
// two-stage owner tag.
//
// Ports:
//   sys_clk, sys_reset            clock, synchronous active-high reset
//   vid_req/addr -> vid_gnt       video read port; vid_rdata/vid_rvalid return data
//   vid_miss                      video denied by the CPU starvation guard
//   cpu_req/we/addr/wdata         CPU read/write port; cpu_gnt, cpu_rdata/cpu_rvalid
//   ldr_req/addr/wdata -> ldr_gnt loader write-only port
//   mem_en/we/addr/wdata          registered RAM command; mem_rdata from RAM
module zed_mem_arbiter #(
   parameter int unsigned AW       = 12,
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          sys_clk,
   input  logic          sys_reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_gnt,
   output logic [DW-1:0] vid_rdata,
   output logic          vid_rvalid,
   output logic          vid_miss,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   input  logic          ldr_req,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   // Owner tags carried alongside the RAM pipeline.
   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_VID  = 2'd1;
   localparam logic [1:0] TAG_CPU  = 2'd2;

   logic [WW-1:0] cpu_wait_q, cpu_wait_d;
   logic          rr_q, rr_d;          // 1 = loader won the last CPU/loader slot
   logic          starve;
   logic [1:0]    tag1_q, tag1_d, tag2_q;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;

   // Grant selection.
   always_comb begin
      vid_gnt  = 1'b0;
      cpu_gnt  = 1'b0;
      ldr_gnt  = 1'b0;
      vid_miss = 1'b0;
      starve   = cpu_req && (cpu_wait_q == WAIT_MAX);
      if (!sys_reset) begin
         if (starve) begin
            cpu_gnt  = 1'b1;
            vid_miss = vid_req;
         end else if (vid_req) begin
            vid_gnt = 1'b1;
         end else if (cpu_req && ldr_req) begin
            // The party that did not win last time gets this slot.
            if (rr_q) cpu_gnt = 1'b1;
            else      ldr_gnt = 1'b1;
         end else if (cpu_req) begin
            cpu_gnt = 1'b1;
         end else if (ldr_req) begin
            ldr_gnt = 1'b1;
         end
      end
   end

   // Next state: starvation counter, round-robin pointer, RAM command, tag.
   always_comb begin
      cpu_wait_d = cpu_wait_q;
      if (!cpu_req || cpu_gnt) begin
         cpu_wait_d = '0;
      end else if (cpu_wait_q != WAIT_MAX) begin
         cpu_wait_d = cpu_wait_q + WW'(1);
      end

      rr_d = rr_q;
      if (cpu_gnt) rr_d = 1'b0;
      if (ldr_gnt) rr_d = 1'b1;

      mem_en_d    = vid_gnt || cpu_gnt || ldr_gnt;
      mem_we_d    = (cpu_gnt && cpu_we) || ldr_gnt;
      // Address and write data hold when idle to avoid needless toggling.
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (vid_gnt) mem_addr_d = vid_addr;
      if (cpu_gnt) begin
         mem_addr_d = cpu_addr;
         if (cpu_we) mem_wdata_d = cpu_wdata;
      end
      if (ldr_gnt) begin
         mem_addr_d  = ldr_addr;
         mem_wdata_d = ldr_wdata;
      end

      tag1_d = TAG_NONE;
      if (vid_gnt)                tag1_d = TAG_VID;
      else if (cpu_gnt && !cpu_we) tag1_d = TAG_CPU;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         cpu_wait_q  <= '0;
         rr_q        <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tag1_q      <= TAG_NONE;
         tag2_q      <= TAG_NONE;
      end else begin
         cpu_wait_q  <= cpu_wait_d;
         rr_q        <= rr_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag1_q;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // rvalid is masked during reset so a read landing in the reset cycle is dropped too.
   assign vid_rvalid = !sys_reset && (tag2_q == TAG_VID);
   assign cpu_rvalid = !sys_reset && (tag2_q == TAG_CPU);
   assign vid_rdata  = mem_rdata;
   assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_zed_mem_arbiter.sv
// Bench for zed_mem_arbiter: a stimulus process drives requests and predicts grants
// from the arbitration rules. It keeps a byte-array image of RAM and queues the
// expected read data for each accepted read. A monitor pops and compares whenever
// rvalid is due.
module tb_zed_mem_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int W_NONE = 0, W_VID = 1, W_CPU = 2, W_LDR = 3;

   logic        sys_clk = 1'b0;
   logic        sys_reset = 1'b1;
   logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0;
   logic [11:0] vid_addr = '0, cpu_addr = '0, ldr_addr = '0;
   logic [7:0]  cpu_wdata = '0, ldr_wdata = '0;
   logic        vid_gnt, vid_rvalid, vid_miss, cpu_gnt, cpu_rvalid, ldr_gnt;
   logic [7:0]  vid_rdata, cpu_rdata;
   logic        mem_en, mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;

   zed_mem_arbiter #(.AW(12), .DW(8), .MAX_WAIT(MAX_WAIT)) dut (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_gnt   (vid_gnt),
      .vid_rdata (vid_rdata),
      .vid_rvalid(vid_rvalid),
      .vid_miss  (vid_miss),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rdata (cpu_rdata),
      .cpu_rvalid(cpu_rvalid),
      .ldr_req   (ldr_req),
      .ldr_addr  (ldr_addr),
      .ldr_wdata (ldr_wdata),
      .ldr_gnt   (ldr_gnt),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 sys_clk = ~sys_clk;

   // Synchronous single-port RAM, one-cycle read latency.
   logic [7:0] ram [4096];
   always @(posedge sys_clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference state.
   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;
   exp_t       vq[$];
   exp_t       cq[$];
   logic [7:0] mm [4096];
   int         m_wait = 0;
   logic       m_rr = 1'b1;   // 1: loader won last
   logic       prev_en = 1'b0, prev_we = 1'b0;
   logic [11:0] prev_addr = '0;
   logic [7:0]  prev_wdata = '0;

   // Requester-side pending transactions, held until granted.
   logic        v_pend = 0, c_pend = 0, c_we = 0, l_pend = 0;
   logic [11:0] v_addr = '0, c_addr = '0, l_addr = '0;
   logic [7:0]  c_wdata = '0, l_wdata = '0;

   logic mon_on = 1'b0;

   always @(negedge sys_clk) begin
      if (mon_on) begin
         logic ev, ec;
         ev = (vq.size() > 0) && (vq[0].due == cyc);
         check("vid_rvalid", vid_rvalid, ev);
         if (ev) begin
            if (vid_rvalid) check("vid_rdata", vid_rdata, vq[0].data);
            void'(vq.pop_front());
         end
         ec = (cq.size() > 0) && (cq[0].due == cyc);
         check("cpu_rvalid", cpu_rvalid, ec);
         if (ec) begin
            if (cpu_rvalid) check("cpu_rdata", cpu_rdata, cq[0].data);
            void'(cq.pop_front());
         end
      end
   end

   task automatic drive();
      vid_req   = v_pend;
      vid_addr  = v_addr;
      cpu_req   = c_pend;
      cpu_we    = c_we;
      cpu_addr  = c_addr;
      cpu_wdata = c_wdata;
      ldr_req   = l_pend;
      ldr_addr  = l_addr;
      ldr_wdata = l_wdata;
   endtask

   // One clock of normal operation: drive, predict, compare, update the model.
   task automatic step();
      int   win;
      logic miss, creq;
      @(posedge sys_clk);
      #1;
      sys_reset = 1'b0;
      drive();
      creq = c_pend;
      miss = 1'b0;
      if (c_pend && m_wait == MAX_WAIT) begin
         win  = W_CPU;
         miss = v_pend;
      end else if (v_pend)            win = W_VID;
      else if (c_pend && l_pend)      win = m_rr ? W_CPU : W_LDR;
      else if (c_pend)                win = W_CPU;
      else if (l_pend)                win = W_LDR;
      else                            win = W_NONE;
      @(negedge sys_clk);
      check("vid_gnt", vid_gnt, win == W_VID);
      check("cpu_gnt", cpu_gnt, win == W_CPU);
      check("ldr_gnt", ldr_gnt, win == W_LDR);
      check("vid_miss", vid_miss, miss);
      check("mem_en", mem_en, prev_en);
      if (prev_en) begin
         check("mem_we", mem_we, prev_we);
         check("mem_addr", mem_addr, prev_addr);
         if (prev_we) check("mem_wdata", mem_wdata, prev_wdata);
      end
      prev_en = (win != W_NONE);
      case (win)
         W_VID: begin
            vq.push_back('{data: mm[v_addr], due: cyc + 2});
            prev_we = 1'b0; prev_addr = v_addr; v_pend = 1'b0;
         end
         W_CPU: begin
            prev_we = c_we; prev_addr = c_addr; prev_wdata = c_wdata;
            if (c_we) mm[c_addr] = c_wdata;
            else      cq.push_back('{data: mm[c_addr], due: cyc + 2});
            c_pend = 1'b0; m_rr = 1'b0;
         end
         W_LDR: begin
            prev_we = 1'b1; prev_addr = l_addr; prev_wdata = l_wdata;
            mm[l_addr] = l_wdata;
            l_pend = 1'b0; m_rr = 1'b1;
         end
         default: ;
      endcase
      if (!creq || win == W_CPU) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
   endtask

   // Asserts reset for n cycles; the following step() releases it.
   task automatic do_reset(input int n);
      @(posedge sys_clk);
      #1;
      sys_reset = 1'b1;
      drive();
      vq.delete();
      cq.delete();
      m_wait  = 0;
      m_rr    = 1'b1;
      prev_en = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge sys_clk);
            #1;
         end
         @(negedge sys_clk);
         check("rst_gnt", {vid_gnt, cpu_gnt, ldr_gnt, vid_miss}, 4'b0);
         if (i > 0) begin
            check("rst_mem_en", mem_en, 1'b0);
            check("rst_mem_we", mem_we, 1'b0);
            check("rst_mem_addr", mem_addr, 12'h0);
            check("rst_mem_wdata", mem_wdata, 8'h0);
         end
      end
   endtask

   task automatic ldr_write(input logic [11:0] a, input logic [7:0] d);
      l_pend = 1'b1; l_addr = a; l_wdata = d;
      step();
   endtask

   function automatic logic [11:0] rand_addr();
      logic [3:0] lo;
      lo = 4'($urandom);
      return ($urandom_range(0, 1) == 1) ? {8'hff, lo} : {8'h00, lo};
   endfunction

   initial begin
      int k;
      for (int i = 0; i < 4096; i++) begin
         ram[i] = 8'h00;
         mm[i]  = 8'h00;
      end
      do_reset(3);
      mon_on = 1'b1;

      // Boot bytes from the loader, CPU idle.
      ldr_write(12'h000, 8'ha2);
      ldr_write(12'h001, 8'h00);
      ldr_write(12'h002, 8'h4c);

      // Vectors, then back-to-back CPU reads of them.
      ldr_write(12'hffc, 8'h00);
      ldr_write(12'hffd, 8'h03);
      c_pend = 1; c_we = 0; c_addr = 12'hffc; step();
      c_pend = 1; c_we = 0; c_addr = 12'hffd; step();
      repeat (3) step();

      // Continuous video against a CPU read: CPU wins on the 5th cycle.
      ldr_write(12'h0ff, 8'hff);
      c_pend = 1; c_we = 0; c_addr = 12'h0ff;
      k = 0;
      while (c_pend && k < 20) begin
         if (!v_pend) begin v_pend = 1; v_addr = rand_addr(); end
         step();
         k++;
      end
      check("starve_cycles", k, 5);
      repeat (6) begin
         if (!v_pend) begin v_pend = 1; v_addr = rand_addr(); end
         step();
      end
      repeat (3) step();

      // CPU write then video read of the same address.
      c_pend = 1; c_we = 1; c_addr = 12'h009; c_wdata = 8'h17; step();
      v_pend = 1; v_addr = 12'h009; step();
      repeat (3) step();

      // CPU and loader contending, no video: alternate, CPU first.
      do_reset(2);
      for (int i = 0; i < 8; i++) begin
         if (!c_pend) begin c_pend = 1; c_we = 0; c_addr = rand_addr(); end
         if (!l_pend) begin l_pend = 1; l_addr = 12'h800 + 12'(i); l_wdata = 8'(i); end
         step();
      end
      c_pend = 0; l_pend = 0;
      repeat (3) step();

      // Reset while a CPU read is in flight.
      c_pend = 1; c_we = 0; c_addr = 12'h0ff; step();
      do_reset(3);
      c_pend = 1; c_we = 0; c_addr = 12'h000;
      l_pend = 1; l_addr = 12'h010; l_wdata = 8'h5a;
      step();
      repeat (4) step();

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         int p;
         p = (i < 600) ? 70 : 25;
         if (i == 900) do_reset(2);
         if (!v_pend && $urandom_range(0, 99) < p) begin
            v_pend = 1; v_addr = rand_addr();
         end
         if (!c_pend && $urandom_range(0, 99) < p) begin
            c_pend = 1; c_we = 1'($urandom); c_addr = rand_addr(); c_wdata = 8'($urandom);
         end
         if (!l_pend && $urandom_range(0, 99) < p / 2) begin
            l_pend = 1; l_addr = rand_addr(); l_wdata = 8'($urandom);
         end
         step();
      end

      // Drain outstanding requests and reads.
      k = 0;
      while ((v_pend || c_pend || l_pend) && k < 50) begin
         step();
         k++;
      end
      repeat (4) step();
      check("vid_queue_empty", vq.size(), 0);
      check("cpu_queue_empty", cq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/zed_mem_arbiter.md
Name: zed_mem_arbiter

Overview:
- Shares the single-port 4 KB chip RAM between three requesters: video fetch (line buffer refill), the 6502 CPU, and a host loader that writes boot code and vectors.
- Sits in nexys4_top between the requesters and the RAM.
- Video has strict priority, with a starvation guard for the CPU; CPU and loader share the remaining slots round-robin.
- One RAM access per cycle, fixed 2-cycle read latency.

Parameters:
- AW, 12, address width (4 KB).
- DW, 8, data width.
- MAX_WAIT, 4, number of consecutive denied CPU cycles that forces a CPU grant over video.

Ports:
- sys_clk  in  1  system clock.
- sys_reset  in  1  synchronous, active-high reset.
- vid_req  in  1  video read request.
- vid_addr  in  AW  video read address.
- vid_gnt  out  1  video request accepted this cycle.
- vid_rdata  out  DW  video read data.
- vid_rvalid  out  1  vid_rdata valid.
- vid_miss  out  1  one-cycle pulse: video request denied by the starvation guard.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rdata  out  DW  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid.
- ldr_req  in  1  loader write request (write-only port).
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_gnt  out  1  loader request accepted this cycle.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data (synchronous RAM, 1-cycle latency).

Behaviour:
- Grants: combinational from the current requests and registered state. At most one gnt is high per cycle.
- Handshake: a requester holds req, addr, we and wdata stable until it sees gnt high. A transfer occurs on any cycle where req && gnt. The requester may change its inputs, or drop req, in the cycle after gnt.
- Priority order:
  - (1) CPU, if cpu_req && cpu_wait == MAX_WAIT.
  - (2) Video.
  - (3) CPU or loader, round-robin. Pointer rr = last winner of the pair; the other party wins when both request. rr updates only on a CPU or loader grant.
- cpu_wait: counter of width clog2(MAX_WAIT+1).
  - Increments on each cycle with cpu_req && !cpu_gnt, saturating at MAX_WAIT.
  - Clears on a CPU grant, and whenever cpu_req = 0.
- vid_miss: pulses in a cycle where vid_req = 1 and the CPU won through rule (1). No other effect; video retries.
- Pipeline:
  - Cycle N: grant.
  - N+1: mem_en/mem_we/mem_addr/mem_wdata are registered copies of the winner's command (mem_en = 0 when there is no grant).
  - N+2: mem_rdata is valid. The matching rvalid is high for exactly one cycle, and rdata = mem_rdata passed through combinationally.
  - A 2-stage owner tag {none, vid, cpu_rd} shifts with the pipeline. Writes and loader accesses carry tag none and produce no rvalid.
- Throughput: one grant every cycle. Back-to-back video reads return one datum per cycle, in order.
- rdata outputs: when the corresponding rvalid = 0, rdata is don't-care. The bench must check rdata only when rvalid = 1.
- Reset (sys_reset sampled high on a sys_clk edge):
  - All gnt, rvalid, vid_miss, mem_en and mem_we outputs are 0.
  - mem_addr and mem_wdata are 0.
  - cpu_wait = 0; rr = loader, so the CPU wins the first contended slot; owner tags are cleared.
  - In-flight reads are dropped, and no rvalid is emitted for them after reset deasserts.
  - While reset is high, gnt outputs are forced to 0.
- Simultaneous requests, all three in one cycle:
  - With cpu_wait < MAX_WAIT, video wins.
  - With cpu_wait == MAX_WAIT, the CPU wins and vid_miss = 1. The loader waits in both cases.
- Same-address CPU write followed by video read: the read in the next slot returns the new data (RAM write-first is not required; the one-cycle pipeline ordering guarantees it).
- Address wrap: no arithmetic on addresses. 12'hfff is a normal address.

Test Plan:
- Reset, then loader writes 0xa2, 0x00, 0x4c to addresses 0x000–0x002 while the CPU is idle → ldr_gnt high on 3 consecutive cycles; mem_we = 1 with addr 0x000..0x002 one cycle later; no rvalid.
- CPU reads 0xffc and 0xffd back-to-back after the loader wrote 0x00 and 0x03 → cpu_rvalid on 2 consecutive cycles, 2 cycles after each grant, with data 0x00 then 0x03.
- vid_req held high continuously, with CPU reading 0x0ff (=0xff) → CPU waits 4 cycles; the 5th cycle gives cpu_gnt = 1 and vid_miss = 1; cpu_rdata = 0xff 2 cycles later; video grants resume the next cycle; video rvalid sequence shows exactly one gap.
- CPU and loader both requesting continuously, no video → grants alternate cpu, ldr, cpu, ldr…, starting with the CPU after reset.
- CPU read granted, then sys_reset asserted in cycle N+1 → no cpu_rvalid in N+2 or later; all outputs 0 during reset; normal operation in the first cycle after reset deasserts.
- CPU writes 0x17 to 0x009, with a video read of 0x009 in the next cycle → vid_rdata = 0x17 when vid_rvalid = 1.
